// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side request/response signals and the memory-macro
// signals seen by mem_port_arbiter; the slave modport is the arbiter's view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_rd_en;
  logic        dm_wr_en;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        halt;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        dm_valid;
  logic [15:0] dm_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        halted;
  logic        err;

  modport slave (
    input  if_req, if_addr, dm_rd_en, dm_wr_en, dm_addr, dm_wdata, halt,
           mem_done, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, if_valid, if_instr,
           dm_valid, dm_rdata, stall_if, stall_mem, halted, err
  );

  modport master (
    output if_req, if_addr, dm_rd_en, dm_wr_en, dm_addr, dm_wdata, halt,
           mem_done, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, if_valid, if_instr,
           dm_valid, dm_rdata, stall_if, stall_mem, halted, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer: one access at a time, data before fetch,
// halt stops fetching, protocol errors and memory timeouts latch a sticky err.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mem_port_arbiter_if.slave    bus
);
  localparam int unsigned     CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DATA   = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          halt_seen_q, halt_seen_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mem_en_s, mem_wr_s, if_valid_s, dm_valid_s;
  logic [15:0]   mem_addr_s, mem_wdata_s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      wr_q        <= 1'b0;
      halt_seen_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      halt_seen_q <= halt_seen_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    halt_seen_d = halt_seen_q | bus.halt;
    mem_en_s    = 1'b0;
    mem_wr_s    = 1'b0;
    mem_addr_s  = 16'h0000;
    mem_wdata_s = 16'h0000;
    if_valid_s  = 1'b0;
    dm_valid_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.dm_rd_en && bus.dm_wr_en) begin
          state_d = ST_ERR;
        end else if (bus.dm_rd_en || bus.dm_wr_en) begin
          // Data first: the memory-stage instruction is older than the fetch.
          mem_en_s    = 1'b1;
          mem_wr_s    = bus.dm_wr_en;
          mem_addr_s  = bus.dm_addr;
          mem_wdata_s = bus.dm_wdata;
          addr_d      = bus.dm_addr;
          wdata_d     = bus.dm_wdata;
          wr_d        = bus.dm_wr_en;
          state_d     = ST_DATA;
        end else if (halt_seen_q || bus.halt) begin
          state_d = ST_HALTED;
        end else if (bus.if_req) begin
          mem_en_s   = 1'b1;
          mem_addr_s = bus.if_addr;
          addr_d     = bus.if_addr;
          wdata_d    = 16'h0000;
          wr_d       = 1'b0;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH, ST_DATA: begin
        mem_en_s    = 1'b1;
        mem_wr_s    = wr_q;
        mem_addr_s  = addr_q;
        mem_wdata_s = wdata_q;
        if (bus.mem_done) begin
          if_valid_s = (state_q == ST_FETCH);
          dm_valid_s = (state_q == ST_DATA);
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_ERR;
    endcase
  end

  // Every output reads as zero while reset is held, combinational paths included.
  assign bus.mem_en    = rst_ni & mem_en_s;
  assign bus.mem_wr    = rst_ni & mem_wr_s;
  assign bus.mem_addr  = rst_ni ? mem_addr_s : 16'h0000;
  assign bus.mem_wdata = rst_ni ? mem_wdata_s : 16'h0000;
  assign bus.if_valid  = rst_ni & if_valid_s;
  assign bus.if_instr  = (rst_ni && if_valid_s) ? bus.mem_rdata : 16'h0000;
  assign bus.dm_valid  = rst_ni & dm_valid_s;
  assign bus.dm_rdata  = (rst_ni && dm_valid_s && !wr_q) ? bus.mem_rdata : 16'h0000;
  assign bus.stall_if  = rst_ni & bus.if_req & ~if_valid_s;
  assign bus.stall_mem = rst_ni & (bus.dm_rd_en | bus.dm_wr_en) & ~dm_valid_s;
  assign bus.halted    = rst_ni & (state_q == ST_HALTED);
  assign bus.err       = rst_ni & (state_q == ST_ERR);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// halt/timeout/reset sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  typedef struct packed {
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        halt;
    logic        mem_done;
    logic [15:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        dm_valid;
    logic [15:0] dm_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        halted;
    logic        err;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input in_t v);
    rst_n         = v.rst_n;
    bus.if_req    = v.if_req;
    bus.if_addr   = v.if_addr;
    bus.dm_rd_en  = v.dm_rd;
    bus.dm_wr_en  = v.dm_wr;
    bus.dm_addr   = v.dm_addr;
    bus.dm_wdata  = v.dm_wdata;
    bus.halt      = v.halt;
    bus.mem_done  = v.mem_done;
    bus.mem_rdata = v.mem_rdata;
  endtask

  function automatic out_t sample();
    out_t g;
    g.mem_en    = bus.mem_en;
    g.mem_wr    = bus.mem_wr;
    g.mem_addr  = bus.mem_addr;
    g.mem_wdata = bus.mem_wdata;
    g.if_valid  = bus.if_valid;
    g.if_instr  = bus.if_instr;
    g.dm_valid  = bus.dm_valid;
    g.dm_rdata  = bus.dm_rdata;
    g.stall_if  = bus.stall_if;
    g.stall_mem = bus.stall_mem;
    g.halted    = bus.halted;
    g.err       = bus.err;
    return g;
  endfunction

  task automatic cmp_out(input string nm, input int idx, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  task automatic cmp16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // One cycle: inputs settle just after the rising edge, outputs are read at the falling edge.
  task automatic cycle(input in_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
  endtask

  function automatic in_t mk(input logic r, input logic ifr, input logic [15:0] ia,
                             input logic rd, input logic wr, input logic [15:0] da,
                             input logic [15:0] dw, input logic h, input logic d,
                             input logic [15:0] rdat);
    in_t v;
    v = '{r, ifr, ia, rd, wr, da, dw, h, d, rdat};
    return v;
  endfunction

  // Transaction-level reference: one outstanding access, a wait count, and two sticky flags.
  bit          m_busy, m_is_data, m_stop, m_dead, m_hseen, m_awr;
  int          m_wait;
  logic [15:0] m_aaddr, m_awd;

  function automatic out_t model_out(input in_t v);
    out_t e;
    e = '0;
    if (v.rst_n) begin
      if (m_dead) e.err = 1'b1;
      else if (m_stop) e.halted = 1'b1;
      else if (m_busy) begin
        e.mem_en = 1'b1;
        e.mem_wr = m_awr;
        e.mem_addr = m_aaddr;
        e.mem_wdata = m_awd;
        if (v.mem_done && m_is_data) begin
          e.dm_valid = 1'b1;
          e.dm_rdata = m_awr ? 16'h0000 : v.mem_rdata;
        end else if (v.mem_done) begin
          e.if_valid = 1'b1;
          e.if_instr = v.mem_rdata;
        end
      end else if (v.dm_rd && v.dm_wr) begin
        e.mem_en = 1'b0;
      end else if (v.dm_rd || v.dm_wr) begin
        e.mem_en = 1'b1;
        e.mem_wr = v.dm_wr;
        e.mem_addr = v.dm_addr;
        e.mem_wdata = v.dm_wdata;
      end else if (!(m_hseen || v.halt) && v.if_req) begin
        e.mem_en = 1'b1;
        e.mem_addr = v.if_addr;
      end
      e.stall_if  = v.if_req & ~e.if_valid;
      e.stall_mem = (v.dm_rd | v.dm_wr) & ~e.dm_valid;
    end
    return e;
  endfunction

  task automatic model_step(input in_t v);
    bit hs;
    if (!v.rst_n) begin
      m_busy = 0; m_is_data = 0; m_stop = 0; m_dead = 0; m_hseen = 0; m_awr = 0;
      m_wait = 0; m_aaddr = 16'h0000; m_awd = 16'h0000;
    end else begin
      hs = m_hseen | v.halt;
      if (m_dead || m_stop) begin
        m_hseen = hs;
      end else if (m_busy) begin
        if (v.mem_done) begin
          m_busy = 0;
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            m_dead = 1;
            m_busy = 0;
          end
        end
      end else if (v.dm_rd && v.dm_wr) begin
        m_dead = 1;
      end else if (v.dm_rd || v.dm_wr) begin
        m_busy = 1; m_is_data = 1; m_awr = v.dm_wr; m_aaddr = v.dm_addr; m_awd = v.dm_wdata;
        m_wait = 0;
      end else if (hs) begin
        m_stop = 1;
      end else if (v.if_req) begin
        m_busy = 1; m_is_data = 0; m_awr = 0; m_aaddr = v.if_addr; m_awd = 16'h0000;
        m_wait = 0;
      end
      m_hseen = hs;
    end
  endtask

  vec_t tbl[16];
  in_t  v;
  in_t  nv;
  out_t e;
  int   dead_cnt;

  initial begin
    checks = 0;
    errors = 0;
    drive(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0));

    tbl[0]  = '{mk(0,1,16'h0010,0,0,16'h0000,16'h0000,0,0,16'h0000), '{1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0}};
    tbl[1]  = '{mk(1,1,16'h0010,0,0,16'h0000,16'h0000,0,0,16'h0000), '{1'b1,1'b0,16'h0010,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0}};
    tbl[2]  = '{mk(1,1,16'h0010,0,0,16'h0000,16'h0000,0,1,16'hC0A5), '{1'b1,1'b0,16'h0010,16'h0000,1'b1,16'hC0A5,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0}};
    tbl[3]  = '{mk(1,0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'hAAAA), '{1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0}};
    tbl[4]  = '{mk(1,1,16'h0020,1,0,16'h0100,16'h0000,0,0,16'h0000), '{1'b1,1'b0,16'h0100,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b1,1'b0,1'b0}};
    tbl[5]  = '{mk(1,1,16'h0020,1,0,16'h0100,16'h0000,0,1,16'h1234), '{1'b1,1'b0,16'h0100,16'h0000,1'b0,16'h0000,1'b1,16'h1234,1'b1,1'b0,1'b0,1'b0}};
    tbl[6]  = '{mk(1,1,16'h0020,0,0,16'h0000,16'h0000,0,0,16'h0000), '{1'b1,1'b0,16'h0020,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0}};
    tbl[7]  = '{mk(1,1,16'h0020,0,0,16'h0000,16'h0000,0,1,16'h5678), '{1'b1,1'b0,16'h0020,16'h0000,1'b1,16'h5678,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0}};
    tbl[8]  = '{mk(1,0,16'h0000,0,1,16'h0200,16'hBEEF,0,0,16'h0000), '{1'b1,1'b1,16'h0200,16'hBEEF,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0}};
    tbl[9]  = '{mk(1,0,16'h0000,0,1,16'h0200,16'hBEEF,0,0,16'h0000), '{1'b1,1'b1,16'h0200,16'hBEEF,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0}};
    tbl[10] = '{mk(1,0,16'h0000,0,1,16'h0200,16'hBEEF,0,1,16'hFFFF), '{1'b1,1'b1,16'h0200,16'hBEEF,1'b0,16'h0000,1'b1,16'h0000,1'b0,1'b0,1'b0,1'b0}};
    tbl[11] = '{mk(1,0,16'h0000,1,1,16'h0300,16'h0000,0,0,16'h0000), '{1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0}};
    tbl[12] = '{mk(1,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000), '{1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1}};
    tbl[13] = '{mk(0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000), '{1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0}};
    tbl[14] = '{mk(1,1,16'h0030,0,0,16'h0000,16'h0000,0,0,16'h0000), '{1'b1,1'b0,16'h0030,16'h0000,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0}};
    tbl[15] = '{mk(1,1,16'h0030,0,0,16'h0000,16'h0000,0,1,16'h0ABC), '{1'b1,1'b0,16'h0030,16'h0000,1'b1,16'h0ABC,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0}};

    for (int k = 0; k < 16; k++) begin
      cycle(tbl[k].i);
      cmp_out("vec", k, sample(), tbl[k].o);
    end

    // Halt during a fetch: the fetch still completes, then fetching stops.
    cycle(mk(1,1,16'h0040,0,0,16'h0,16'h0,0,0,16'h0));
    cmp16("halt_issue_en", {15'd0, bus.mem_en}, 16'd1);
    cycle(mk(1,1,16'h0040,0,0,16'h0,16'h0,1,0,16'h0));
    cmp16("halt_wait_valid", {15'd0, bus.if_valid}, 16'd0);
    cycle(mk(1,1,16'h0040,0,0,16'h0,16'h0,0,1,16'h1111));
    cmp16("halt_done_instr", bus.if_instr, 16'h1111);
    cycle(mk(1,1,16'h0042,0,0,16'h0,16'h0,0,0,16'h0));
    cmp16("halt_noissue_en", {15'd0, bus.mem_en}, 16'd0);
    cmp16("halt_stall_if", {15'd0, bus.stall_if}, 16'd1);
    cycle(mk(1,1,16'h0042,0,0,16'h0,16'h0,0,0,16'h0));
    cmp16("halted_flag", {14'd0, bus.halted, bus.mem_en}, 16'b10);
    cycle(mk(0,0,16'h0,0,0,16'h0,16'h0,0,0,16'h0));
    cmp16("halt_rst_clear", {14'd0, bus.halted, bus.err}, 16'd0);

    // Timeout: TO waiting cycles without mem_done, then sticky err.
    cycle(mk(1,1,16'h0050,0,0,16'h0,16'h0,0,0,16'h0));
    cmp16("to_issue_en", {15'd0, bus.mem_en}, 16'd1);
    for (int k = 1; k <= TO; k++) begin
      cycle(mk(1,1,16'h0050,0,0,16'h0,16'h0,0,0,16'h0));
      cmp16("to_wait", {14'd0, bus.mem_en, bus.err}, 16'b10);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(mk(1,1,16'h0050,0,0,16'h0,16'h0,0,1,16'h0));
      cmp16("to_err_sticky", {14'd0, bus.mem_en, bus.err}, 16'b01);
    end
    cycle(mk(0,1,16'h0050,0,0,16'h0,16'h0,0,0,16'h0));
    cmp16("to_rst_err", {14'd0, bus.stall_if, bus.err}, 16'd0);

    // Reset mid-access abandons the access without a valid.
    cycle(mk(1,1,16'h0060,0,0,16'h0,16'h0,0,0,16'h0));
    cmp16("rma_issue_addr", bus.mem_addr, 16'h0060);
    cycle(mk(0,1,16'h0060,0,0,16'h0,16'h0,0,1,16'h7777));
    cmp16("rma_dropped", {14'd0, bus.mem_en, bus.if_valid}, 16'd0);
    cycle(mk(1,1,16'h0064,0,0,16'h0,16'h0,0,1,16'h7777));
    cmp16("rma_reissue_addr", bus.mem_addr, 16'h0064);
    cmp16("rma_done_ignored", {15'd0, bus.if_valid}, 16'd0);
    cycle(mk(1,1,16'h0064,0,0,16'h0,16'h0,0,1,16'h4321));
    cmp16("rma_instr", bus.if_instr, 16'h4321);

    // Random traffic against the reference model.
    v = mk(0,0,16'h0,0,0,16'h0,16'h0,0,0,16'h0);
    dead_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      cycle(v);
      e = model_out(v);
      cmp_out("rand", n, sample(), e);
      model_step(v);
      nv = v;
      if (!v.rst_n) begin
        nv.if_req = 1'b0;
        nv.dm_rd  = 1'b0;
        nv.dm_wr  = 1'b0;
      end else begin
        if (e.if_valid || !v.if_req) begin
          nv.if_req  = ($urandom_range(0, 3) != 0);
          nv.if_addr = 16'($urandom);
        end
        if (e.dm_valid || !(v.dm_rd || v.dm_wr)) begin
          case ($urandom_range(0, 63))
            0:       begin nv.dm_rd = 1'b1; nv.dm_wr = 1'b1; end
            1,2,3,4,5,6,7,8,9,10,11,12: begin nv.dm_rd = 1'b1; nv.dm_wr = 1'b0; end
            13,14,15,16,17,18,19,20,21,22,23: begin nv.dm_rd = 1'b0; nv.dm_wr = 1'b1; end
            default: begin nv.dm_rd = 1'b0; nv.dm_wr = 1'b0; end
          endcase
          nv.dm_addr  = 16'($urandom);
          nv.dm_wdata = 16'($urandom);
        end
      end
      dead_cnt    = (m_dead || m_stop) ? dead_cnt + 1 : 0;
      nv.rst_n    = !(dead_cnt >= 3 || $urandom_range(0, 199) == 0);
      nv.halt     = ($urandom_range(0, 149) == 0);
      nv.mem_done = ($urandom_range(0, 2) != 0);
      nv.mem_rdata = 16'($urandom);
      v = nv;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
